// File: rtl/clock_set_controller.sv
// Button-driven edit sequencer for the digital clock: captures the running time,
// lets the user step hours/minutes/seconds and alarm fields, then commits them.
module clock_set_controller #(
    parameter int unsigned HOLD_CYCLES      = 25_000_000,
    parameter int unsigned REPEAT_CYCLES    = 5_000_000,
    parameter int unsigned TIMEOUT_CYCLES   = 500_000_000,
    parameter int unsigned LOAD_HOLD_CYCLES = 60_000_000
) (
    input  logic       clk_50Mhz,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_ok,
    input  logic [7:0] cur_hours,
    input  logic [7:0] cur_minutes,
    input  logic [7:0] cur_seconds,
    output logic       load_time,
    output logic [7:0] load_hours,
    output logic [7:0] load_minutes,
    output logic [7:0] load_seconds,
    output logic       set_alarm_enable,
    output logic [7:0] set_alarm_hours,
    output logic [7:0] set_alarm_minutes,
    output logic [2:0] edit_field,
    output logic       busy
);

    typedef enum logic [2:0] {
        RUN, T_HR, T_MIN, T_SEC, A_HR, A_MIN, COMMIT_T, COMMIT_A
    } state_t;

    state_t      state, state_next;
    logic        btn_mode_q, btn_inc_q, btn_dec_q, btn_ok_q;
    logic        mode_rise, inc_rise, dec_rise, ok_rise, any_rise;
    logic        in_edit, in_time_edit, single, single_rise, hold_active, step_now, timed_out;
    logic        repeating, commit_done;
    logic [31:0] hold_cnt, idle_cnt, commit_cnt, hold_limit;
    logic [7:0]  eh, em, es, ah, am;

    function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    function automatic logic [7:0] step_field(input logic [7:0] v, input logic [7:0] max_v,
                                              input logic up);
        if (up) return (v >= max_v) ? 8'd0 : v + 8'd1;
        else    return (v == 8'd0) ? max_v : v - 8'd1;
    endfunction

    always_comb begin
        mode_rise    = btn_mode & ~btn_mode_q;
        inc_rise     = btn_inc & ~btn_inc_q;
        dec_rise     = btn_dec & ~btn_dec_q;
        ok_rise      = btn_ok & ~btn_ok_q;
        any_rise     = mode_rise | inc_rise | dec_rise | ok_rise;
        in_time_edit = (state == T_HR) || (state == T_MIN) || (state == T_SEC);
        in_edit      = in_time_edit || (state == A_HR) || (state == A_MIN);
        // Exactly one of inc/dec held; mode or ok on the same cycle suppresses stepping
        single       = btn_inc ^ btn_dec;
        single_rise  = (btn_inc & inc_rise) | (btn_dec & dec_rise);
        hold_limit   = repeating ? REPEAT_CYCLES : HOLD_CYCLES;
        hold_active  = in_edit & ~mode_rise & ~ok_rise & single;
        step_now     = hold_active & (single_rise | (hold_cnt == hold_limit));
        timed_out    = in_edit & ~any_rise & ~step_now & (idle_cnt >= TIMEOUT_CYCLES);
        commit_done  = (commit_cnt >= LOAD_HOLD_CYCLES - 1);
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (mode_rise) state_next = T_HR;
            T_HR:     if (ok_rise) state_next = COMMIT_T;
                      else if (mode_rise) state_next = T_MIN;
                      else if (timed_out) state_next = RUN;
            T_MIN:    if (ok_rise) state_next = COMMIT_T;
                      else if (mode_rise) state_next = T_SEC;
                      else if (timed_out) state_next = RUN;
            T_SEC:    if (ok_rise) state_next = COMMIT_T;
                      else if (mode_rise) state_next = A_HR;
                      else if (timed_out) state_next = RUN;
            A_HR:     if (ok_rise) state_next = COMMIT_A;
                      else if (mode_rise) state_next = A_MIN;
                      else if (timed_out) state_next = RUN;
            A_MIN:    if (ok_rise) state_next = COMMIT_A;
                      else if (mode_rise || timed_out) state_next = RUN;
            COMMIT_T,
            COMMIT_A: if (commit_done) state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_comb begin
        load_time        = (state == COMMIT_T);
        set_alarm_enable = (state == COMMIT_A);
        busy             = (state != RUN);
        case (state)
            T_HR:    edit_field = 3'd1;
            T_MIN:   edit_field = 3'd2;
            T_SEC:   edit_field = 3'd3;
            A_HR:    edit_field = 3'd4;
            A_MIN:   edit_field = 3'd5;
            default: edit_field = 3'd0;
        endcase
    end

    always_ff @(posedge clk_50Mhz) begin
        if (reset) begin
            state             <= RUN;
            btn_mode_q        <= 1'b0;
            btn_inc_q         <= 1'b0;
            btn_dec_q         <= 1'b0;
            btn_ok_q          <= 1'b0;
            hold_cnt          <= '0;
            repeating         <= 1'b0;
            idle_cnt          <= '0;
            commit_cnt        <= '0;
            eh                <= '0;
            em                <= '0;
            es                <= '0;
            ah                <= '0;
            am                <= '0;
            load_hours        <= '0;
            load_minutes      <= '0;
            load_seconds      <= '0;
            set_alarm_hours   <= '0;
            set_alarm_minutes <= '0;
        end else begin
            state      <= state_next;
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
            btn_dec_q  <= btn_dec;
            btn_ok_q   <= btn_ok;

            // A fresh press restarts the initial hold delay; later steps use the repeat period
            if (!hold_active) begin
                hold_cnt  <= '0;
                repeating <= 1'b0;
            end else if (step_now) begin
                hold_cnt  <= 32'd1;
                repeating <= ~single_rise;
            end else begin
                hold_cnt  <= hold_cnt + 32'd1;
            end

            if (!in_edit || any_rise || step_now) idle_cnt <= '0;
            else                                  idle_cnt <= idle_cnt + 32'd1;

            if (state == COMMIT_T || state == COMMIT_A) commit_cnt <= commit_cnt + 32'd1;
            else                                        commit_cnt <= '0;

            if (state == RUN && mode_rise) begin
                eh <= clamp(cur_hours, 8'd23);
                em <= clamp(cur_minutes, 8'd59);
                es <= clamp(cur_seconds, 8'd59);
            end

            if (state == T_SEC && state_next == A_HR) begin
                ah <= set_alarm_hours;
                am <= set_alarm_minutes;
            end

            if (step_now) begin
                case (state)
                    T_HR:    eh <= step_field(eh, 8'd23, btn_inc);
                    T_MIN:   em <= step_field(em, 8'd59, btn_inc);
                    T_SEC:   es <= step_field(es, 8'd59, btn_inc);
                    A_HR:    ah <= step_field(ah, 8'd23, btn_inc);
                    A_MIN:   am <= step_field(am, 8'd59, btn_inc);
                    default: ;
                endcase
            end

            if (in_edit && ok_rise) begin
                if (in_time_edit) begin
                    load_hours   <= eh;
                    load_minutes <= em;
                    load_seconds <= es;
                end else begin
                    set_alarm_hours   <= ah;
                    set_alarm_minutes <= am;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller: a field/wrap-arithmetic model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_clock_set_controller;

    localparam int HOLD = 4;
    localparam int REPEAT = 2;
    localparam int TIMEOUT = 50;
    localparam int LOAD = 3;

    logic       clk_50Mhz, reset;
    logic       btn_mode, btn_inc, btn_dec, btn_ok;
    logic [7:0] cur_hours, cur_minutes, cur_seconds;
    logic       load_time, set_alarm_enable, busy;
    logic [7:0] load_hours, load_minutes, load_seconds, set_alarm_hours, set_alarm_minutes;
    logic [2:0] edit_field;

    int checks = 0;
    int passes = 0;
    int hi;

    clock_set_controller #(
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT),
        .TIMEOUT_CYCLES(TIMEOUT), .LOAD_HOLD_CYCLES(LOAD)
    ) dut (
        .clk_50Mhz(clk_50Mhz), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_ok(btn_ok),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .load_time(load_time), .load_hours(load_hours), .load_minutes(load_minutes),
        .load_seconds(load_seconds), .set_alarm_enable(set_alarm_enable),
        .set_alarm_hours(set_alarm_hours), .set_alarm_minutes(set_alarm_minutes),
        .edit_field(edit_field), .busy(busy)
    );

    initial begin
        clk_50Mhz = 1'b0;
        forever #5 clk_50Mhz = ~clk_50Mhz;
    end

    // Model: field index 0..5, values kept as ints wrapped modulo (limit+1)
    bit model_valid = 0;
    int cyc = 0;
    int fld, commit_left, hold_start, last_act;
    bit commit_alarm;
    int val[6];
    int lim[6] = '{0, 23, 59, 59, 23, 59};
    int exp_lh, exp_lm, exp_ls, exp_ah, exp_am;
    bit pm, pi, pd, po;

    function automatic int clampv(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk_50Mhz) begin : model
        bit rm, ri, rd, ro, stepped;
        int el;
        cyc++;
        if (reset) begin
            model_valid = 1;
            fld = 0; commit_left = 0; commit_alarm = 0;
            for (int k = 0; k < 6; k++) val[k] = 0;
            exp_lh = 0; exp_lm = 0; exp_ls = 0; exp_ah = 0; exp_am = 0;
            pm = 0; pi = 0; pd = 0; po = 0;
            hold_start = cyc + 1; last_act = cyc;
        end else begin
            rm = btn_mode && !pm;
            ri = btn_inc && !pi;
            rd = btn_dec && !pd;
            ro = btn_ok && !po;
            stepped = 0;
            if (commit_left > 0) begin
                commit_left--;
                hold_start = cyc + 1;
            end else if (fld == 0) begin
                hold_start = cyc + 1;
                if (rm) begin
                    fld = 1;
                    val[1] = clampv(int'(cur_hours), 23);
                    val[2] = clampv(int'(cur_minutes), 59);
                    val[3] = clampv(int'(cur_seconds), 59);
                    last_act = cyc;
                end
            end else if (ro) begin
                if (fld <= 3) begin
                    exp_lh = val[1]; exp_lm = val[2]; exp_ls = val[3];
                    commit_alarm = 0;
                end else begin
                    exp_ah = val[4]; exp_am = val[5];
                    commit_alarm = 1;
                end
                commit_left = LOAD;
                fld = 0;
                hold_start = cyc + 1;
            end else if (rm) begin
                if (fld == 5) fld = 0;
                else begin
                    fld++;
                    if (fld == 4) begin
                        val[4] = exp_ah;
                        val[5] = exp_am;
                    end
                end
                last_act = cyc;
                hold_start = cyc + 1;
            end else begin
                if (btn_inc == btn_dec) hold_start = cyc + 1;
                else begin
                    if ((btn_inc && ri) || (btn_dec && rd)) begin
                        stepped = 1;
                        hold_start = cyc;
                    end else begin
                        el = cyc - hold_start;
                        if (el >= HOLD && ((el - HOLD) % REPEAT) == 0) stepped = 1;
                    end
                    if (stepped) begin
                        if (btn_inc) val[fld] = (val[fld] + 1) % (lim[fld] + 1);
                        else         val[fld] = (val[fld] + lim[fld]) % (lim[fld] + 1);
                    end
                end
                if (rm || ri || rd || ro || stepped) last_act = cyc;
                else if (cyc - last_act - 1 >= TIMEOUT) fld = 0;
            end
            pm = btn_mode; pi = btn_inc; pd = btn_dec; po = btn_ok;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk_50Mhz) begin
        logic [45:0] dut_vec, exp_vec;
        if (model_valid) begin
            dut_vec = {load_time, load_hours, load_minutes, load_seconds, set_alarm_enable,
                       set_alarm_hours, set_alarm_minutes, edit_field, busy};
            exp_vec = {(commit_left > 0) && !commit_alarm, 8'(exp_lh), 8'(exp_lm), 8'(exp_ls),
                       (commit_left > 0) && commit_alarm, 8'(exp_ah), 8'(exp_am), 3'(fld),
                       (fld != 0) || (commit_left > 0)};
            checks++;
            if (dut_vec !== exp_vec)
                $display("[TB] FAIL model_cycle %0d: got %h expected %h", cyc, dut_vec, exp_vec);
            else
                passes++;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        else
            passes++;
    endtask

    task automatic applyStimulus(input logic m, input logic i, input logic d, input logic o,
                                 input int n);
        btn_mode = m; btn_inc = i; btn_dec = d; btn_ok = o;
        repeat (n) @(negedge clk_50Mhz);
    endtask

    task automatic press(input logic m, input logic i, input logic d, input logic o);
        applyStimulus(m, i, d, o, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic enterEdit(input int h, input int m, input int s);
        cur_hours = 8'(h); cur_minutes = 8'(m); cur_seconds = 8'(s);
        press(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, LOAD + 2);
    endtask

    initial begin
        reset = 1'b1;
        btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_ok = 0;
        cur_hours = 0; cur_minutes = 0; cur_seconds = 0;
        repeat (2) @(negedge clk_50Mhz);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_edit_field", int'(edit_field), 0);
        checkOutput("reset_load_time", int'(load_time), 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 2);

        // Basic edit and commit of the hour field
        cur_hours = 12; cur_minutes = 34; cur_seconds = 56;
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("t1_edit_field", int'(edit_field), 1);
        applyStimulus(0, 0, 0, 0, 1);
        repeat (3) press(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("t1_load_time", int'(load_time), 1);
        checkOutput("t1_load_hours", int'(load_hours), 15);
        checkOutput("t1_load_minutes", int'(load_minutes), 34);
        checkOutput("t1_load_seconds", int'(load_seconds), 56);
        hi = 1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            if (load_time) hi++;
        end
        checkOutput("t1_strobe_len", hi, 3);
        checkOutput("t1_busy_after", int'(busy), 0);

        // Wrap-around on hours and minutes, clamping of out-of-range capture
        enterEdit(23, 59, 0); press(0, 1, 0, 0); press(0, 0, 0, 1);
        checkOutput("t2_hr_wrap_up", int'(load_hours), 0);
        settle();
        enterEdit(0, 0, 0); press(0, 0, 1, 0); press(0, 0, 0, 1);
        checkOutput("t2_hr_wrap_down", int'(load_hours), 23);
        settle();
        enterEdit(0, 0, 0); press(0, 0, 1, 0); press(0, 0, 1, 0); press(0, 0, 0, 1);
        checkOutput("t2_hr_dec_twice", int'(load_hours), 22);
        settle();
        enterEdit(12, 59, 0); press(1, 0, 0, 0); press(0, 1, 0, 0); press(0, 0, 0, 1);
        checkOutput("t2_min_wrap_up", int'(load_minutes), 0);
        settle();
        enterEdit(12, 0, 0); press(1, 0, 0, 0); press(0, 0, 1, 0); press(0, 0, 0, 1);
        checkOutput("t2_min_wrap_down", int'(load_minutes), 59);
        settle();
        enterEdit(30, 200, 75); press(0, 0, 0, 1);
        checkOutput("t2_clamp_hours", int'(load_hours), 23);
        checkOutput("t2_clamp_minutes", int'(load_minutes), 59);
        checkOutput("t2_clamp_seconds", int'(load_seconds), 59);
        settle();

        // Auto-repeat: steps on the rise and at hold cycles 4, 6, 8
        enterEdit(12, 0, 0); press(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 10);
        applyStimulus(0, 0, 0, 0, 1);
        press(0, 0, 0, 1);
        checkOutput("t3_autorepeat", int'(load_minutes), 4);
        settle();

        // Alarm edit: hours by presses, minutes by a 61-cycle hold
        enterEdit(12, 34, 56);
        repeat (3) press(1, 0, 0, 0);
        checkOutput("t4_edit_field_ahr", int'(edit_field), 4);
        repeat (7) press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        checkOutput("t4_edit_field_amin", int'(edit_field), 5);
        applyStimulus(0, 1, 0, 0, 61);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("t4_alarm_enable", int'(set_alarm_enable), 1);
        checkOutput("t4_alarm_hours", int'(set_alarm_hours), 7);
        checkOutput("t4_alarm_minutes", int'(set_alarm_minutes), 30);
        checkOutput("t4_load_time_low", int'(load_time), 0);
        hi = 1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            if (set_alarm_enable) hi++;
        end
        checkOutput("t4_strobe_len", hi, 3);
        enterEdit(1, 2, 3);
        repeat (3) press(1, 0, 0, 0);
        press(0, 0, 0, 1);
        checkOutput("t4_reload_hours", int'(set_alarm_hours), 7);
        checkOutput("t4_reload_minutes", int'(set_alarm_minutes), 30);
        settle();

        // Idle timeout abandons the edit
        enterEdit(12, 34, 56);
        applyStimulus(0, 0, 0, 0, 44);
        checkOutput("t5_still_busy", int'(busy), 1);
        applyStimulus(0, 0, 0, 0, 10);
        checkOutput("t5_timeout_busy", int'(busy), 0);
        checkOutput("t5_timeout_field", int'(edit_field), 0);

        // Reset during the second cycle of a time commit
        enterEdit(12, 34, 56);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("t5_commit_started", int'(load_time), 1);
        applyStimulus(0, 0, 0, 0, 1);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t5_reset_load_time", int'(load_time), 0);
        checkOutput("t5_reset_busy", int'(busy), 0);
        checkOutput("t5_reset_load_hours", int'(load_hours), 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 2);

        // Priority: ok beats mode, mode beats inc, inc+dec together does nothing
        enterEdit(12, 34, 56); press(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("t6_ok_wins", int'(load_time), 1);
        checkOutput("t6_ok_wins_field", int'(edit_field), 0);
        settle();
        enterEdit(12, 34, 56); press(1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 10);
        applyStimulus(0, 0, 0, 0, 1);
        press(0, 0, 0, 1);
        checkOutput("t6_inc_dec_both", int'(load_minutes), 34);
        settle();
        cur_hours = 12; cur_minutes = 34; cur_seconds = 56;
        press(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("t6_mode_wins_field", int'(edit_field), 2);
        applyStimulus(0, 0, 0, 0, 1);
        press(0, 0, 0, 1);
        checkOutput("t6_mode_wins_hours", int'(load_hours), 12);
        checkOutput("t6_mode_wins_minutes", int'(load_minutes), 34);
        settle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
